// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store unit.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  localparam int unsigned TimeoutCyclesDefault = 16;

  localparam logic [3:0] BeWord   = 4'b1111;
  localparam logic [3:0] BeHalfLo = 4'b0011;
  localparam logic [3:0] BeHalfHi = 4'b1100;
  localparam logic [3:0] BeByte0  = 4'b0001;
  localparam logic [3:0] BeByte1  = 4'b0010;
  localparam logic [3:0] BeByte2  = 4'b0100;
  localparam logic [3:0] BeByte3  = 4'b1000;

  // Byte enables must match the access size and sit on the lane the address selects.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] off);
    logic ok;
    case (be)
      BeWord:   ok = (off == 2'b00);
      BeHalfLo: ok = (off == 2'b00);
      BeHalfHi: ok = (off == 2'b10);
      BeByte0:  ok = (off == 2'b00);
      BeByte1:  ok = (off == 2'b01);
      BeByte2:  ok = (off == 2'b10);
      BeByte3:  ok = (off == 2'b11);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate sub-word store data across all lanes so the enabled lane carries it.
  function automatic logic [31:0] store_lanes(input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] res;
    if (be == BeWord) begin
      res = wd;
    end else if (be == BeHalfLo || be == BeHalfHi) begin
      res = {2{wd[15:0]}};
    end else begin
      res = {4{wd[7:0]}};
    end
    return res;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read beat and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [3:0]  be_i,
  input  logic        load_signed_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select and extension by access size.
  always_comb begin
    byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    if (be_i == BeWord) begin
      result_o = rdata_i;
    end else if (be_i == BeHalfLo || be_i == BeHalfHi) begin
      result_o = {{16{load_signed_i & half_v[15]}}, half_v};
    end else begin
      result_o = {{24{load_signed_i & byte_v[7]}}, byte_v};
    end
  end

endmodule

// File: rtl/ldst_unit.sv
// Load/store unit: turns a datapath memory request into one handshaked bus transaction.
module ldst_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [3:0]  be,
  input  logic        LoadSigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemErr,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value during the last permitted REQ/WAIT cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic            signed_q, signed_d;
  logic            valid_q, valid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     aligned;
  logic            timed_out;

  load_align u_load_align (
    .rdata_i       (bus_rdata),
    .addr_lo_i     (addr_q[1:0]),
    .be_i          (be_q),
    .load_signed_i (signed_q),
    .result_o      (aligned)
  );

  assign timed_out = (cnt_q >= CntLast);

  // Next-state logic; a bus accept or read beat takes priority over a same-cycle timeout.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    signed_d = signed_q;
    valid_d  = valid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (MemReq) begin
          rdata_d = '0;
          if (be_legal(be, Addr[1:0])) begin
            addr_d   = Addr;
            wdata_d  = store_lanes(be, WriteData);
            be_d     = be;
            we_d     = MemWrite;
            signed_d = LoadSigned;
            valid_d  = 1'b1;
            err_d    = 1'b0;
            cnt_d    = '0;
            state_d  = StReq;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus_ready) begin
          valid_d = 1'b0;
          state_d = we_q ? StDone : StWait;
        end else if (timed_out) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus_rvalid) begin
          rdata_d = aligned;
          state_d = StDone;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered bus/result outputs; reset drops bus_valid immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      signed_q <= signed_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // The core may only commit in DONE or in an IDLE cycle without a request.
  always_comb begin
    Stall = 1'b0;
    unique case (state_q)
      StIdle:  Stall = MemReq;
      StReq:   Stall = 1'b1;
      StWait:  Stall = 1'b1;
      StDone:  Stall = 1'b0;
      default: Stall = 1'b0;
    endcase
  end

  assign bus_valid = valid_q;
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign ReadData  = rdata_q;
  assign MemErr    = err_q;

endmodule

// File: tb/tb_ldst_unit.sv
// Self-checking bench for ldst_unit: directed table, random transactions, reset corner cases.
module tb_ldst_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq, MemWrite, LoadSigned;
  logic [3:0]  be;
  logic [31:0] Addr, WriteData;
  logic [31:0] ReadData;
  logic        Stall, MemErr;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int passes = 0;

  ldst_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReq     (MemReq),
    .MemWrite   (MemWrite),
    .be         (be),
    .LoadSigned (LoadSigned),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .MemErr     (MemErr),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model working from the access rules with plain arithmetic.
  task automatic model(input logic we, input logic [3:0] be_v, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int rdy, input int rv,
                       output int e_stall, output logic e_err, output logic [31:0] e_rd,
                       output int e_beats, output logic [31:0] e_wdata);
    int a, n, r, k, lim;
    logic legal;
    logic [31:0] mask, val;
    a = int'(addr[1:0]);
    n = $countones(be_v);
    legal = (n == 1 || n == 2 || n == 4) && (a % n == 0) &&
            (int'(be_v) == (((1 << n) - 1) << a));
    if (n == 4) e_wdata = wdata;
    else if (n == 2) e_wdata = 32'(wdata[15:0]) * 32'h0001_0001;
    else e_wdata = 32'(wdata[7:0]) * 32'h0101_0101;
    e_rd = '0;
    r = rdy + 1;
    if (!legal) begin
      e_stall = 1; e_err = 1'b1; e_beats = 0;
    end else if (r > T) begin
      e_stall = 1 + T; e_err = 1'b1; e_beats = 0;
    end else if (we) begin
      e_stall = 1 + r; e_err = 1'b0; e_beats = 1;
    end else begin
      e_beats = 1;
      k = r + rv + 1;
      lim = (r + 1 > T) ? r + 1 : T;
      e_err = (k > lim);
      e_stall = 1 + (e_err ? lim : k);
      if (!e_err) begin
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        val = (rdata >> (8 * a)) & mask;
        if (sgn && n < 4 && val[8 * n - 1]) val = val | ~mask;
        e_rd = val;
      end
    end
  endtask

  // Drives one request, plays the bus side with the given delays, checks everything.
  task automatic apply(input string tag, input logic we, input logic [3:0] be_v,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int rdy, input int rv,
                       input int e_stall, input logic e_err, input logic [31:0] e_rd,
                       input int e_beats, input logic [31:0] e_wdata);
    int stalls, beats, vcyc, acc_cyc;
    bit hung, unstable, accepted;
    logic [68:0] prev, cur;
    logic [31:0] b_addr, b_wdata, rd;
    logic [3:0] b_be;
    logic b_we, err;
    stalls = 0; beats = 0; vcyc = 0; acc_cyc = 0;
    hung = 1; unstable = 0; accepted = 0;
    prev = '0; b_addr = '0; b_wdata = '0; b_be = '0; b_we = 0; rd = '0; err = 0;
    @(negedge clk);
    MemReq = 1; MemWrite = we; be = be_v; LoadSigned = sgn; Addr = addr; WriteData = wdata;
    for (int cyc = 0; cyc < 60; cyc++) begin
      bus_ready = 0; bus_rvalid = 0;
      #1;
      if (!Stall) begin
        err = MemErr; rd = ReadData; hung = 0;
        break;
      end
      stalls++;
      if (bus_valid) begin
        cur = {bus_addr, bus_wdata, bus_be, bus_we};
        if (vcyc > 0 && cur !== prev) unstable = 1;
        prev = cur;
        if (vcyc == rdy) begin
          bus_ready = 1; beats++; accepted = 1; acc_cyc = cyc;
          b_addr = bus_addr; b_wdata = bus_wdata; b_be = bus_be; b_we = bus_we;
        end
        vcyc++;
      end else if (accepted && !we && (cyc - acc_cyc) == rv + 1) begin
        bus_rvalid = 1; bus_rdata = rdata;
      end
      @(negedge clk);
    end
    MemReq = 0;
    check({tag, " done reached"}, 32'(hung), 32'd0);
    check({tag, " stall cycles"}, 32'(stalls), 32'(e_stall));
    check({tag, " MemErr"}, 32'(err), 32'(e_err));
    check({tag, " ReadData"}, rd, e_rd);
    check({tag, " bus beats"}, 32'(beats), 32'(e_beats));
    check({tag, " request stable"}, 32'(unstable), 32'd0);
    if (e_beats > 0) begin
      check({tag, " bus_addr"}, b_addr, addr & 32'hFFFF_FFFC);
      check({tag, " bus_be"}, 32'(b_be), 32'(be_v));
      check({tag, " bus_we"}, 32'(b_we), 32'(we));
      if (we) check({tag, " bus_wdata"}, b_wdata, e_wdata);
    end
    @(negedge clk);
    #1;
    check({tag, " idle no stall"}, 32'(Stall), 32'd0);
    check({tag, " idle no valid"}, 32'(bus_valid), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy;
    int          rv;
    int          stall;
    logic        err;
    logic [31:0] rd;
    int          beats;
    logic [31:0] bwd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int e_stall, e_beats, rdy, rv, off, n;
    logic e_err, we_r, sgn_r;
    logic [31:0] e_rd, e_wd, addr_r;
    logic [3:0] be_r;

    vecs[0] = '{1, 4'hF, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 2, 0, 32'h0, 1, 32'hDEADBEEF};
    vecs[1] = '{0, 4'h8, 1, 32'h203, 32'h0, 32'h80112233, 0, 0, 3, 0, 32'hFFFFFF80, 1, 32'h0};
    vecs[2] = '{0, 4'h8, 0, 32'h203, 32'h0, 32'h80112233, 0, 0, 3, 0, 32'h00000080, 1, 32'h0};
    vecs[3] = '{1, 4'hC, 0, 32'h42, 32'h0000ABCD, 32'h0, 3, 0, 5, 0, 32'h0, 1, 32'hABCDABCD};
    vecs[4] = '{1, 4'h6, 0, 32'h10, 32'h12345678, 32'h0, 0, 0, 1, 1, 32'h0, 0, 32'h0};
    vecs[5] = '{0, 4'hF, 0, 32'h300, 32'h0, 32'h55AA55AA, 0, 99, 5, 1, 32'h0, 1, 32'h0};
    vecs[6] = '{0, 4'hC, 1, 32'h2, 32'h0, 32'h80011234, 0, 0, 3, 0, 32'hFFFF8001, 1, 32'h0};
    vecs[7] = '{0, 4'h2, 0, 32'h1, 32'h0, 32'h0000FF00, 0, 2, 5, 0, 32'h000000FF, 1, 32'h0};
    vecs[8] = '{0, 4'hF, 0, 32'h22, 32'h0, 32'h0, 0, 0, 1, 1, 32'h0, 0, 32'h0};

    reset = 1; MemReq = 0; MemWrite = 0; be = 0; LoadSigned = 0; Addr = 0; WriteData = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    check("reset bus_valid", 32'(bus_valid), 32'd0);
    check("reset bus_we", 32'(bus_we), 32'd0);
    check("reset bus_addr", bus_addr, 32'd0);
    check("reset bus_wdata", bus_wdata, 32'd0);
    check("reset bus_be", 32'(bus_be), 32'd0);
    check("reset ReadData", ReadData, 32'd0);
    check("reset MemErr", 32'(MemErr), 32'd0);
    check("reset Stall", 32'(Stall), 32'd0);

    for (int i = 0; i < 9; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].we, vecs[i].be, vecs[i].sgn, vecs[i].addr,
            vecs[i].wdata, vecs[i].rdata, vecs[i].rdy, vecs[i].rv, vecs[i].stall,
            vecs[i].err, vecs[i].rd, vecs[i].beats, vecs[i].bwd);
    end

    for (int i = 0; i < 40; i++) begin
      we_r = 1'($urandom_range(0, 1));
      sgn_r = 1'($urandom_range(0, 1));
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) begin
        be_r = 4'($urandom_range(0, 15));
      end else begin
        n = (off == 0) ? (1 << $urandom_range(0, 2)) : (off == 2) ? $urandom_range(1, 2) : 1;
        be_r = 4'(((1 << n) - 1) << off);
      end
      addr_r = {$urandom() >> 2, 2'b00} | 32'(off);
      rdy = we_r ? $urandom_range(0, 4) : $urandom_range(0, 2);
      rv = $urandom_range(0, 3);
      begin
        logic [31:0] wd_r, rd_r;
        wd_r = $urandom();
        rd_r = $urandom();
        model(we_r, be_r, sgn_r, addr_r, wd_r, rd_r, rdy, rv,
              e_stall, e_err, e_rd, e_beats, e_wd);
        apply($sformatf("rand%0d", i), we_r, be_r, sgn_r, addr_r, wd_r, rd_r, rdy, rv,
              e_stall, e_err, e_rd, e_beats, e_wd);
      end
    end

    // Leave a nonzero result behind so the reset clearing it is observable.
    apply("preload", 0, 4'hF, 0, 32'h400, 32'h0, 32'h11111111, 0, 0,
          3, 0, 32'h11111111, 1, 32'h0);

    // Reset while the request is being presented drops bus_valid at once.
    @(negedge clk);
    MemReq = 1; MemWrite = 1; be = 4'hF; Addr = 32'h500; WriteData = 32'hCAFEF00D;
    bus_ready = 0;
    @(negedge clk);
    #1;
    check("req bus_valid up", 32'(bus_valid), 32'd1);
    reset = 1;
    #1;
    check("reset in REQ bus_valid", 32'(bus_valid), 32'd0);
    check("reset in REQ ReadData", ReadData, 32'd0);
    MemReq = 0;
    @(negedge clk);
    reset = 0;

    apply("preload2", 0, 4'hF, 0, 32'h600, 32'h0, 32'h22222222, 0, 0,
          3, 0, 32'h22222222, 1, 32'h0);

    // Reset while waiting for read data; a late rvalid must be ignored.
    @(negedge clk);
    MemReq = 1; MemWrite = 0; be = 4'hF; Addr = 32'h700; bus_ready = 0;
    @(negedge clk);
    bus_ready = 1;
    @(negedge clk);
    bus_ready = 0;
    #1;
    check("wait stall", 32'(Stall), 32'd1);
    reset = 1; MemReq = 0;
    #1;
    check("reset in WAIT bus_valid", 32'(bus_valid), 32'd0);
    check("reset in WAIT stall low", 32'(Stall), 32'd0);
    MemReq = 1;
    #1;
    check("reset in WAIT stall follows MemReq", 32'(Stall), 32'd1);
    MemReq = 0;
    @(negedge clk);
    reset = 0; bus_rvalid = 1; bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_rvalid = 0;
    #1;
    check("late rvalid ReadData", ReadData, 32'd0);
    check("late rvalid MemErr", 32'(MemErr), 32'd0);
    check("late rvalid stall", 32'(Stall), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
